// File: rtl/r_forward_queue.sv
// ---------------------------------------------------------------------------
// r_forward_queue
//
// Buffers the packed 77-bit AR request stream coming from the read-forward
// mixer and hands it to the read router. The target slave index is decoded
// from the address at enqueue time and stored alongside the payload, so the
// router sees a ready-made slave index and decode-error flag for the head.
// Every output is driven from registered state, which breaks all
// combinational paths between the upstream and downstream handshakes.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, minimum 2)
//   SLAVE_NUM  number of populated slaves (1..16)
//
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-high reset
//   DATA        packed AR request in (ARADDR at [68:33])
//   VALID       upstream request valid
//   READY       queue can accept a request (registered state only)
//   O_DATA      head request payload, unmodified
//   O_SLAVE     head slave index (ARADDR[35:32])
//   O_DECERR    head slave index is at or above SLAVE_NUM
//   O_VALID     head entry valid
//   O_READY     downstream accepts head entry
//   COUNT       current occupancy
//   DECERR_CNT  saturating count of enqueued decode-error requests
// ---------------------------------------------------------------------------
module r_forward_queue #(
  parameter int DEPTH     = 4,
  parameter int SLAVE_NUM = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [76:0]              DATA,
  input  logic                     VALID,
  output logic                     READY,
  output logic [76:0]              O_DATA,
  output logic [3:0]               O_SLAVE,
  output logic                     O_DECERR,
  output logic                     O_VALID,
  input  logic                     O_READY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [7:0]               DECERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry holds {payload, slave index, decode error}.
  logic [81:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_decerrCnt;

  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_slave;
  logic          w_decerr;
  logic [81:0]   w_head;

  // Slave index is the top nibble of the 36-bit ARADDR.
  assign w_slave  = DATA[68:65];
  assign w_decerr = ({1'b0, w_slave} >= 5'(SLAVE_NUM));

  // Full/empty come from the occupancy counter, not pointer equality.
  assign READY   = (r_count != CW'(DEPTH));
  assign O_VALID = (r_count != '0);

  assign w_push = VALID && READY;
  assign w_pop  = O_VALID && O_READY;

  assign w_head   = r_mem[r_rdPtr];
  assign O_DATA   = w_head[81:5];
  assign O_SLAVE  = w_head[4:1];
  assign O_DECERR = w_head[0];

  assign COUNT      = r_count;
  assign DECERR_CNT = r_decerrCnt;

  // Storage carries no reset; stale contents are unreachable once the
  // counter is cleared, because O_VALID gates the head.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {DATA, w_slave, w_decerr};
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
    end
  end

  // Simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Decode-error statistics, sticking at 255 until reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_decerrCnt <= '0;
    end else if (w_push && w_decerr && (r_decerrCnt != 8'hFF)) begin
      r_decerrCnt <= r_decerrCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_r_forward_queue.sv
// ---------------------------------------------------------------------------
// tb_r_forward_queue
//
// Directed bench for r_forward_queue. The stimulus side pushes the expected
// head contents into a scoreboard queue at the moment a request is accepted;
// a monitor pops and compares whenever the DUT completes an output
// handshake. Direct checks cover reset state, occupancy and flags.
// ---------------------------------------------------------------------------
module tb_r_forward_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [76:0] DATA;
  logic        VALID;
  logic        READY;
  logic [76:0] O_DATA;
  logic [3:0]  O_SLAVE;
  logic        O_DECERR;
  logic        O_VALID;
  logic        O_READY;
  logic [2:0]  COUNT;
  logic [7:0]  DECERR_CNT;

  int          assertCount = 0;
  int          failCount   = 0;
  int          cycle       = 0;
  logic [81:0] sb [$];

  r_forward_queue #(.DEPTH(4), .SLAVE_NUM(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA       (DATA),
    .VALID      (VALID),
    .READY      (READY),
    .O_DATA     (O_DATA),
    .O_SLAVE    (O_SLAVE),
    .O_DECERR   (O_DECERR),
    .O_VALID    (O_VALID),
    .O_READY    (O_READY),
    .COUNT      (COUNT),
    .DECERR_CNT (DECERR_CNT)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle++;

  // Build a request with fixed side fields around the given ID, address, length.
  function automatic logic [76:0] mkReq(input logic [7:0] id, input logic [35:0] addr,
                                        input logic [7:0] len);
    return {id, addr, len, 3'd2, 2'b01, 1'b0, 4'h3, 3'b000, 4'h0, 4'h0, 4'hA};
  endfunction

  task automatic checkOutput(input string name, input logic [81:0] act, input logic [81:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request and hold it until accepted; record the expected head.
  task automatic applyStimulus(input logic [76:0] d, input logic [3:0] expSlave,
                               input logic expDecerr);
    bit accepted = 0;
    DATA  = d;
    VALID = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (READY) begin
        accepted = 1;
        sb.push_back({d, expSlave, expDecerr});
      end
      @(posedge CLK);
      #1;
      if (accepted) break;
    end
    VALID = 1'b0;
    if (!accepted) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL pushTimeout: got READY=0 expected acceptance");
    end
  endtask

  task automatic waitEmpty();
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      if (COUNT == 0) begin
        done = 1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drainTimeout: got COUNT=%0d expected 0", COUNT);
    end
  endtask

  task automatic resetDut();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    sb.delete();
  endtask

  // Monitor: every completed output handshake must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RESET && O_VALID && O_READY) begin
      if (sb.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedOutput: got %h expected nothing", O_DATA);
      end else begin
        checkOutput("headEntry", {O_DATA, O_SLAVE, O_DECERR}, sb.pop_front());
      end
    end
  end

  initial begin
    int          startCyc;
    logic [9:0]  popPat;
    logic [76:0] req;

    VALID   = 1'b0;
    O_READY = 1'b0;
    DATA    = '0;
    resetDut();

    // Reset state
    checkOutput("rstCount",  82'(COUNT),      82'd0);
    checkOutput("rstOValid", 82'(O_VALID),    82'd0);
    checkOutput("rstReady",  82'(READY),      82'd1);
    checkOutput("rstDecCnt", 82'(DECERR_CNT), 82'd0);

    // Single request: ARID 0x11, ARADDR 0x2_0000_1000 -> slave 2
    req = mkReq(8'h11, 36'h2_0000_1000, 8'd3);
    applyStimulus(req, 4'd2, 1'b0);
    checkOutput("singleOValid", 82'(O_VALID),  82'd1);
    checkOutput("singleData",   82'(O_DATA),   82'(req));
    checkOutput("singleSlave",  82'(O_SLAVE),  82'd2);
    checkOutput("singleDecerr", 82'(O_DECERR), 82'd0);
    checkOutput("singleCount",  82'(COUNT),    82'd1);
    O_READY = 1'b1;
    @(posedge CLK);
    #1;
    O_READY = 1'b0;
    checkOutput("singlePopCount",  82'(COUNT),   82'd0);
    checkOutput("singlePopOValid", 82'(O_VALID), 82'd0);

    // Fill to DEPTH with the router stalled; the 5th request waits upstream
    for (int i = 1; i <= 4; i++)
      applyStimulus(mkReq(8'(i), 36'h1_0000_0000 + 36'(i * 64), 8'd0), 4'd1, 1'b0);
    checkOutput("fullReady", 82'(READY), 82'd0);
    checkOutput("fullCount", 82'(COUNT), 82'd4);
    DATA  = mkReq(8'd5, 36'h1_0000_0140, 8'd0);
    VALID = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      checkOutput("heldReady", 82'(READY), 82'd0);
      @(posedge CLK);
      #1;
    end
    checkOutput("heldCount", 82'(COUNT), 82'd4);
    O_READY = 1'b1;
    @(posedge CLK);
    #1;
    O_READY = 1'b0;
    checkOutput("afterPopReady", 82'(READY), 82'd1);
    checkOutput("afterPopCount", 82'(COUNT), 82'd3);
    applyStimulus(mkReq(8'd5, 36'h1_0000_0140, 8'd0), 4'd1, 1'b0);
    checkOutput("refillCount", 82'(COUNT), 82'd4);
    O_READY = 1'b1;
    waitEmpty();
    O_READY = 1'b0;

    // Streaming at occupancy 1
    applyStimulus(mkReq(8'h40, 36'h0_0000_0000, 8'd1), 4'd0, 1'b0);
    O_READY  = 1'b1;
    startCyc = cycle;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mkReq(8'(8'h41 + i), 36'h3_0000_0000 + 36'(i), 8'(i)), 4'd3, 1'b0);
      checkOutput("streamCount", 82'(COUNT), 82'd1);
    end
    checkOutput("streamCycles", 82'(cycle - startCyc), 82'd20);
    waitEmpty();
    O_READY = 1'b0;

    // Decode error: index 7 with four slaves
    applyStimulus(mkReq(8'h77, 36'h7_0000_0000, 8'd0), 4'd7, 1'b1);
    checkOutput("decSlave",  82'(O_SLAVE),    82'd7);
    checkOutput("decFlag",   82'(O_DECERR),   82'd1);
    checkOutput("decCount1", 82'(DECERR_CNT), 82'd1);
    O_READY = 1'b1;
    waitEmpty();
    for (int i = 0; i < 300; i++)
      applyStimulus(mkReq(8'(i), 36'h7_0000_0000 + 36'(i), 8'd0), 4'd7, 1'b1);
    waitEmpty();
    O_READY = 1'b0;
    checkOutput("decSaturate", 82'(DECERR_CNT), 82'd255);

    // Pointer wrap across varying occupancy, from a fresh reset
    resetDut();
    popPat = 10'b1110110100;
    for (int i = 0; i < 10; i++) begin
      O_READY = popPat[i];
      applyStimulus(mkReq(8'(8'h80 + i), 36'h5_0000_0000 + 36'(i * 16), 8'(i)), 4'd5, 1'b1);
      assertCount++;
      if (COUNT > 4) begin
        failCount++;
        $display("[TB] FAIL wrapCountBound: got %0d expected <= 4", COUNT);
      end
    end
    O_READY = 1'b1;
    waitEmpty();
    O_READY = 1'b0;

    // Asynchronous reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++)
      applyStimulus(mkReq(8'(8'hC0 + i), 36'h1_0000_0000, 8'd0), 4'd1, 1'b0);
    checkOutput("preRstCount", 82'(COUNT), 82'd3);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("asyncRstOValid", 82'(O_VALID), 82'd0);
    checkOutput("asyncRstCount",  82'(COUNT),   82'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("postRstReady",  82'(READY),   82'd1);
    checkOutput("postRstOValid", 82'(O_VALID), 82'd0);
    req = mkReq(8'h99, 36'h0_1234_5678, 8'd2);
    applyStimulus(req, 4'd0, 1'b0);
    checkOutput("postRstHead", 82'(O_DATA), 82'(req));
    O_READY = 1'b1;
    waitEmpty();
    O_READY = 1'b0;

    checkOutput("scoreboardEmpty", 82'(sb.size()), 82'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/r_forward_queue.md
Name: r_forward_queue

Overview:
- Consumes the packed 77-bit AR request stream (DATA/VALID/READY) produced by the read-forward mixer stage.
- Buffers requests in a small FIFO and decodes the target slave from the address once, at enqueue.
- Presents each request, with its slave index and a decode-error flag, to the downstream read router.
- Breaks every combinational path between the upstream mixer handshake and the router handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SLAVE_NUM, 4, number of populated slaves, 1..16. A request whose index is at or above SLAVE_NUM is a decode error.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DATA  input  77  packed AR request. Field map:
  - ARID[76:69], ARADDR[68:33], ARLEN[32:25], ARSIZE[24:22], ARBURST[21:20]
  - ARLOCK[19], ARCACHE[18:15], ARPROT[14:12], ARQOS[11:8], ARREGION[7:4], ARUSER[3:0]
- VALID  input  1  upstream request valid.
- READY  output  1  queue can accept a request.
- O_DATA  output  77  head request, passed through unmodified.
- O_SLAVE  output  4  head slave index, equal to ARADDR[35:32] (DATA[68:65]).
- O_DECERR  output  1  head index is at or above SLAVE_NUM.
- O_VALID  output  1  head entry valid.
- O_READY  input  1  downstream accepts the head entry.
- COUNT  output  log2(DEPTH)+1  current occupancy.
- DECERR_CNT  output  8  saturating count of enqueued decode-error requests.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Read pointer, write pointer, COUNT and DECERR_CNT go to 0.
  - O_VALID=0, READY=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all entries. Storage contents are don't-care.
- Push: VALID && READY at a rising edge.
  - Writes {DATA, O_SLAVE value, O_DECERR value} (82 bits) at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: O_VALID && O_READY at a rising edge. Read pointer increments modulo DEPTH.
- Output handshake signals:
  - READY = (COUNT != DEPTH). It depends only on registered state, never on VALID or O_READY.
  - O_VALID = (COUNT != 0).
  - O_DATA, O_SLAVE and O_DECERR are read from the entry at the read pointer. They are held stable while O_VALID && !O_READY.
- Latency:
  - A request pushed at edge N is visible on the outputs after edge N (first-word latency 1 cycle).
  - No bypass path.
- COUNT update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. Legal at any occupancy from 1 to DEPTH-1.
  - When empty, only a push is possible.
  - When full, READY=0, so only a pop is possible. Simultaneous pop-and-push at full is not supported; the freed slot is usable next cycle.
- Pointers:
  - Width log2(DEPTH), natural wrap.
  - Full and empty are distinguished by COUNT, not by pointer equality.
- Decode: combinational from DATA[68:65], registered into the entry at push.
  - O_DECERR = (index >= SLAVE_NUM).
  - Decode-error requests are queued and forwarded like any other request; the router issues the DECERR response.
- DECERR_CNT:
  - +1 on each push with decode error.
  - Saturates at 255.
  - Cleared only by reset.
- Upstream protocol:
  - VALID held without READY is legal; the queue never drops a request.
  - DATA changes while VALID && !READY are sampled only at acceptance.
- The block never modifies payload fields, and order is strictly FIFO.

Test Plan:
- Reset, then a single request: ARID=0x11, ARADDR=0x2_0000_1000, ARLEN=3, pushed at cycle 1.
  - Cycle 2: O_VALID=1, O_DATA equals the input, O_SLAVE=2, O_DECERR=0, COUNT=1.
  - With O_READY=1: COUNT=0 and O_VALID=0 next cycle.
- Fill with O_READY=0: push 5 requests back-to-back into DEPTH=4.
  - READY drops after the 4th push, COUNT=4.
  - The 5th request is held upstream.
  - One pop gives READY=1 next cycle; the 5th request enters, and all 5 drain in order (ARID 1..5).
- Streaming: VALID=1 and O_READY=1 continuously for 20 requests at COUNT=1.
  - COUNT stays 1.
  - Throughput is 1 request per cycle.
  - Output order matches input.
- Decode error with SLAVE_NUM=4: ARADDR[35:32]=0x7.
  - O_SLAVE=7, O_DECERR=1, DECERR_CNT increments to 1.
  - 300 such pushes saturate DECERR_CNT at 255.
- Pointer wrap: 10 push/pop cycles at varying occupancy.
  - Entries 8..10 read back correctly after wrap.
  - COUNT never exceeds 4.
- Reset asserted asynchronously mid-clock with COUNT=3.
  - O_VALID=0 and COUNT=0 immediately, READY=1 after release.
  - Stale entries never appear on the outputs.
